// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index width
// default and the controller state encoding.
package hazard_ctrl_pkg;

  localparam int REG_LOG_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_WAIT = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID-stage source that reads the
// destination of a load currently in EX.
module load_use_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_LOG = REG_LOG_DEF
) (
  input  logic [3*REG_LOG-1:0] rs_ID,
  input  logic [2:0]           rs_used_ID,
  input  logic [REG_LOG-1:0]   rd_EX,
  input  logic                 MEM_read_EX,
  output logic                 hazard
);

  // rs_ID packs {rs0,rs1,rs2}, so rs0 occupies the most significant slice.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rs_used_ID[i] && (rs_ID[(3-i)*REG_LOG-1 -: REG_LOG] == rd_EX))
        hazard = 1'b1;
    end
    if (!MEM_read_EX || (rd_EX == '0))
      hazard = 1'b0;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory/MDU wait FSM, branch flush, load-use
// stall, and a saturating count of stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_LOG = REG_LOG_DEF,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3*REG_LOG-1:0] rs_ID,
  input  logic [2:0]           rs_used_ID,
  input  logic [REG_LOG-1:0]   rd_EX,
  input  logic                 MEM_read_EX,
  input  logic                 mdu_start_EX,
  input  logic                 mdu_done,
  input  logic                 dmem_req_MEM,
  input  logic                 dmem_ack,
  input  logic                 br_taken_EX,
  output logic                 stall_IF,
  output logic                 stall_ID,
  output logic                 stall_EX,
  output logic                 stall_MEM,
  output logic                 flush_ID,
  output logic                 flush_EX,
  output logic                 flush_MEM,
  output logic                 flush_WB,
  output logic [CNT_W-1:0]     stall_cnt
);

  hz_state_t state, state_nxt;
  logic      hazard;
  logic      mem_hold, mdu_hold, br_flush, lu_stall;

  load_use_detect #(.REG_LOG(REG_LOG)) u_load_use_detect (
    .rs_ID       (rs_ID),
    .rs_used_ID  (rs_used_ID),
    .rd_EX       (rd_EX),
    .MEM_read_EX (MEM_read_EX),
    .hazard      (hazard)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_IF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Priority: memory wait > MDU wait > branch flush > load-use.
  always_comb begin
    state_nxt = state;
    mem_hold  = 1'b0;
    mdu_hold  = 1'b0;
    br_flush  = 1'b0;
    lu_stall  = 1'b0;
    case (state)
      RUN: begin
        if (dmem_req_MEM && !dmem_ack) begin
          mem_hold  = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (mdu_start_EX) begin
          mdu_hold  = 1'b1;
          state_nxt = MDU_WAIT;
        end else if (br_taken_EX) begin
          br_flush = 1'b1;
        end else if (hazard) begin
          lu_stall = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) state_nxt = RUN;
        else          mdu_hold  = 1'b1;
      end
      MEM_WAIT: begin
        if (dmem_ack) state_nxt = RUN;
        else          mem_hold  = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are gated by rstn so they drop the moment reset is asserted.
  assign stall_IF  = rstn & (mem_hold | mdu_hold | lu_stall);
  assign stall_ID  = rstn & (mem_hold | mdu_hold | lu_stall);
  assign stall_EX  = rstn & (mem_hold | mdu_hold);
  assign stall_MEM = rstn & mem_hold;
  assign flush_ID  = rstn & br_flush;
  assign flush_EX  = rstn & (br_flush | lu_stall);
  assign flush_MEM = rstn & mdu_hold;
  assign flush_WB  = rstn & mem_hold;

endmodule
